ultra_range_bcd: RTL

//  Drives the ultrasonic sensor trigger, times the echo pulse and converts it to distance in whole cm.

---
 rtl/ultra_range_bcd_pkg.sv | 22 ++
 rtl/ultra_range_bcd_if.sv | 23 ++
 rtl/bin2bcd_seq.sv | 62 ++++++
 rtl/ultra_range_bcd.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/ultra_range_bcd_pkg.sv
// Shared definitions for the ultrasonic range finder: FSM encodings, widths and BCD helper.
package ultra_range_bcd_pkg;

    localparam int unsigned BCD_W = 4;
    localparam int unsigned CM_W  = 14;

    typedef logic [CM_W-1:0] cm_t;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_TRIG = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_MEAS = 3'd3;
    localparam logic [2:0] S_AVG  = 3'd4;
    localparam logic [2:0] S_CONV = 3'd5;
    localparam logic [2:0] S_HOLD = 3'd6;

    // Double-dabble correction applied to each digit before a shift.
    function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] d);
        return (d > 4'd4) ? d + 4'd3 : d;
    endfunction

endpackage

// File: rtl/ultra_range_bcd_if.sv
// Sensor and display-side signals of the range finder.
interface ultra_range_bcd_if;

    logic       echo;
    logic       trig;
    logic [3:0] digit0;
    logic [3:0] digit1;
    logic [3:0] digit2;
    logic [3:0] digit3;
    logic       new_data;
    logic       no_echo;

    modport master (
        output echo,
        input  trig, digit0, digit1, digit2, digit3, new_data, no_echo
    );

    modport slave (
        input  echo,
        output trig, digit0, digit1, digit2, digit3, new_data, no_echo
    );

endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential 14-bit binary to 4-digit BCD converter: one load cycle, then one shift per bit.
module bin2bcd_seq
    import ultra_range_bcd_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  cm_t              bin,
    output logic             done,
    output logic [BCD_W-1:0] bcd0,
    output logic [BCD_W-1:0] bcd1,
    output logic [BCD_W-1:0] bcd2,
    output logic [BCD_W-1:0] bcd3
);

    logic               busy;
    logic [3:0]         step;
    cm_t                bin_sr;
    logic [4*BCD_W-1:0] bcd_sr;
    logic [4*BCD_W-1:0] bcd_adj;
    logic [4*BCD_W-1:0] bcd_next;

    always_comb begin
        bcd_adj  = {add3(bcd_sr[15:12]), add3(bcd_sr[11:8]),
                    add3(bcd_sr[7:4]),   add3(bcd_sr[3:0])};
        bcd_next = (bcd_adj << 1) | {15'd0, bin_sr[CM_W-1]};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy   <= 1'b0;
            step   <= '0;
            bin_sr <= '0;
            bcd_sr <= '0;
            done   <= 1'b0;
            bcd0   <= '0;
            bcd1   <= '0;
            bcd2   <= '0;
            bcd3   <= '0;
        end else begin
            done <= 1'b0;
            if (!busy) begin
                if (start) begin
                    bin_sr <= bin;
                    bcd_sr <= '0;
                    step   <= '0;
                    busy   <= 1'b1;
                end
            end else begin
                bcd_sr <= bcd_next;
                bin_sr <= bin_sr << 1;
                step   <= step + 4'd1;
                if (step == 4'(CM_W - 1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                    {bcd3, bcd2, bcd1, bcd0} <= bcd_next;
                end
            end
        end
    end

endmodule

// File: rtl/ultra_range_bcd.sv
// Free-running ultrasonic ranger: trigger, echo timing, cm conversion and BCD output.
// Define ULTRA_RANGE_AVG_EN to report the mean of the last four valid samples.
module ultra_range_bcd
    import ultra_range_bcd_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 50_000_000,
    parameter int unsigned TRIG_CYC    = CLK_HZ / 100_000,
    parameter int unsigned CM_CYC      = (CLK_HZ / 1_000_000) * 58,
    parameter int unsigned TIMEOUT_CYC = (CLK_HZ / 100) * 3,
    parameter int unsigned PERIOD_CYC  = (CLK_HZ / 100) * 6,
    parameter int unsigned MAX_CM      = 500
) (
    input  logic               clk,
    input  logic               reset,
    ultra_range_bcd_if.slave   bus
);

    localparam int unsigned CNT_MAX = (TIMEOUT_CYC > CM_CYC) ? TIMEOUT_CYC : CM_CYC;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned PER_W   = $clog2(PERIOD_CYC + 1);
`ifdef ULTRA_RANGE_AVG_EN
    localparam logic [2:0]  S_POST_MEAS = S_AVG;
`else
    localparam logic [2:0]  S_POST_MEAS = S_CONV;
`endif

    logic [2:0]       state;
    logic             echo_s1, echo_s2, echo_s3;
    logic             echo_rise;
    logic [PER_W-1:0] per_cnt;
    logic [CNT_W-1:0] cnt;
    cm_t              cm;
    cm_t              conv_bin;
    logic             start;
    logic             done;
    logic [3:0]       c0, c1, c2, c3;
    logic [3:0]       d0, d1, d2, d3;
    logic             new_data;
    logic             no_echo;

    assign echo_rise = echo_s2 & ~echo_s3;

    bin2bcd_seq u_bcd (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .bin   (conv_bin),
        .done  (done),
        .bcd0  (c0),
        .bcd1  (c1),
        .bcd2  (c2),
        .bcd3  (c3)
    );

    // cnt serves as the timeout counter in WAIT and the per-cm cycle counter in MEAS;
    // the rising-edge cycle itself counts as the first echo-high cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            echo_s1  <= 1'b0;
            echo_s2  <= 1'b0;
            echo_s3  <= 1'b0;
            per_cnt  <= '0;
            cnt      <= '0;
            cm       <= '0;
            start    <= 1'b0;
            d0       <= '0;
            d1       <= '0;
            d2       <= '0;
            d3       <= '0;
            new_data <= 1'b0;
            no_echo  <= 1'b0;
        end else begin
            echo_s1  <= bus.echo;
            echo_s2  <= echo_s1;
            echo_s3  <= echo_s2;
            per_cnt  <= per_cnt + PER_W'(1);
            start    <= 1'b0;
            new_data <= 1'b0;
            case (state)
                S_IDLE: begin
                    state   <= S_TRIG;
                    per_cnt <= '0;
                end
                S_TRIG: begin
                    if (per_cnt == PER_W'(TRIG_CYC - 1)) begin
                        state <= S_WAIT;
                        cnt   <= '0;
                    end
                end
                S_WAIT: begin
                    if (echo_rise) begin
                        state <= S_MEAS;
                        cnt   <= CNT_W'(1);
                        cm    <= '0;
                    end else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                        state   <= S_HOLD;
                        no_echo <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_MEAS: begin
                    if (!echo_s2) begin
                        state <= S_POST_MEAS;
                        start <= (S_POST_MEAS == S_CONV);
                    end else if (cnt == CNT_W'(CM_CYC - 1)) begin
                        cnt <= '0;
                        cm  <= cm + CM_W'(1);
                        if (cm == CM_W'(MAX_CM - 1)) begin
                            state <= S_POST_MEAS;
                            start <= (S_POST_MEAS == S_CONV);
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_AVG: begin
                    state <= S_CONV;
                    start <= 1'b1;
                end
                S_CONV: begin
                    if (done) begin
                        state    <= S_HOLD;
                        {d3, d2, d1, d0} <= {c3, c2, c1, c0};
                        new_data <= 1'b1;
                        no_echo  <= 1'b0;
                    end
                end
                S_HOLD: begin
                    if (per_cnt == PER_W'(PERIOD_CYC - 1)) begin
                        state   <= S_TRIG;
                        per_cnt <= '0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef ULTRA_RANGE_AVG_EN
    cm_t         hist0, hist1, hist2;
    logic [2:0]  hist_cnt;
    cm_t         nh1, nh2, nh3;
    logic [CM_W+1:0] sum;
    cm_t         avg;

    // Empty history slots are filled with the newest sample.
    always_comb begin
        nh1 = (hist_cnt >= 3'd1) ? hist0 : cm;
        nh2 = (hist_cnt >= 3'd2) ? hist1 : cm;
        nh3 = (hist_cnt >= 3'd3) ? hist2 : cm;
        sum = {2'b00, cm} + {2'b00, nh1} + {2'b00, nh2} + {2'b00, nh3};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist0    <= '0;
            hist1    <= '0;
            hist2    <= '0;
            hist_cnt <= '0;
            avg      <= '0;
        end else if (state == S_AVG) begin
            hist0 <= cm;
            hist1 <= nh1;
            hist2 <= nh2;
            if (hist_cnt != 3'd4) hist_cnt <= hist_cnt + 3'd1;
            avg <= cm_t'(sum >> 2);
        end
    end

    assign conv_bin = avg;
`else
    assign conv_bin = cm;
`endif

    assign bus.trig     = (state == S_TRIG);
    assign bus.digit0   = d0;
    assign bus.digit1   = d1;
    assign bus.digit2   = d2;
    assign bus.digit3   = d3;
    assign bus.new_data = new_data;
    assign bus.no_echo  = no_echo;

endmodule
